fp_adder_tree_n: RTL and testbench
==================================

# fp_adder_tree_n

Parametrised, pipelined IEEE-754 single-precision reduction tree that sums NUM_IN lanes per beat and can optionally accumulate successive beats into one result. It is the general-width successor to the fixed 8/16-input FP adder trees in the adder-channel group. It sits between the multiplier array and the activation or output stage, with a valid/ready stream on both sides.

## Interface
- NUM_IN, 16: lane count, 2..64; any value is legal, not only powers of two.
- LEVELS, derived as ceil(log2(NUM_IN)): tree depth; not overridable.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- Data_In  in  32*NUM_IN  packed lanes; lane i occupies bits [32i+31:32i].
- Lane_En  in  NUM_IN  per-lane enable; a disabled lane is replaced by +0.0 (0x00000000).
- Valid_In  in  1  input beat valid.
- In_Ready  out  1  input accepted when Valid_In && In_Ready.
- Acc_Mode  in  1  sampled with the beat; 1 accumulates beats until Last.
- Last  in  1  sampled with the beat; closes the accumulation packet; ignored when Acc_Mode=0.
- Data_Out  out  32  sum.
- Valid_Out  out  1  Data_Out valid.
- Out_Ready  in  1  downstream accept.

## Operation
- Lane padding:
  - Level 0 has 2^LEVELS slots.
  - Slots at index NUM_IN and above, and slots of disabled lanes, are +0.0.
- Adder cell:
  - Each cell is an FP_Adder with Mode=0 (add) and RMode=00 (round-to-nearest-even), used combinationally.
  - NaN, Inf and denormal handling is exactly that of FP_Adder.
- Tree pairing:
  - Level k pairs slot 2j with slot 2j+1.
  - This fixes the summation order; it must be bit-exact against a reference model using the same order.
- Pipeline registers:
  - Each level's outputs are registered.
  - valid, Acc_Mode and Last travel in a sideband shift register alongside the data.
- Output/accumulator stage: one final register stage that acts on each valid tree result T as follows.
  - Acc_Mode=0: Data_Out<=T, Valid_Out<=1.
  - Acc_Mode=1, !Last: acc<=(acc_active ? acc : +0.0)+T, acc_active<=1, no output.
  - Acc_Mode=1, Last: Data_Out<=(acc_active ? acc : +0.0)+T, Valid_Out<=1, acc_active<=0.
- Mixed mode: an Acc_Mode=0 beat arriving while acc_active=1 does not disturb acc; its result is output directly and the packet continues.
- Backpressure:
  - stall = Valid_Out && !Out_Ready.
  - In_Ready = !stall.
  - When stalled, every pipeline register, the sideband, acc and acc_active hold.
  - When not stalled, an output beat is consumed on Out_Ready; Valid_Out drops unless a new result lands in the same cycle.
- Lane_En: sampled together with Data_In on acceptance; masking is applied before the level-0 register.

## Timing
- Reset (async assert, sync release): every data register = 0x00000000, every sideband valid = 0, acc = 0, acc_active = 0, Data_Out = 0, Valid_Out = 0. In_Ready = 1 after reset.
- Latency from an accepted beat to Valid_Out (non-accumulating beat, no stall) is LEVELS+1 cycles. NUM_IN=16 gives 5 cycles; NUM_IN=5 gives 4; NUM_IN=2 gives 2.
- Throughput: one beat per cycle when Out_Ready is held high. Accumulating beats add no bubbles, since acc updates every cycle.
- Stall semantics:
  - A stall cycle freezes all state, so latency grows by one cycle per stall cycle.
  - No beat is dropped or duplicated.
  - Data_Out is stable while Valid_Out && !Out_Ready.
- Last with Acc_Mode=1 on the first beat of a packet produces that beat's sum alone.
- Reset asserted mid-packet discards the partial accumulation and all in-flight beats; the first post-reset beat starts a fresh packet.

## Test plan
- NUM_IN=16, all lanes 1.0 (0x3F800000), Lane_En all 1, Acc_Mode=0, one beat -> Data_Out=0x41800000 (16.0) with Valid_Out exactly 5 cycles after acceptance.
- NUM_IN=16, lanes 1.0, Lane_En=0x00FF -> 0x41000000 (8.0). Same beat with lane 3=NaN and lane 3 disabled -> 8.0, i.e. the masked NaN does not propagate.
- NUM_IN=16, Acc_Mode=1, three back-to-back beats of all 1.0 with Last on the third -> a single Valid_Out pulse, Data_Out=0x42400000 (48.0), 5 cycles after the third beat; no output for beats 1 and 2.
- NUM_IN=5, lanes 1.0,2.0,3.0,4.0,5.0 -> 0x41700000 (15.0) after 4 cycles. Check bit-exact order with lanes 1e8, -1e8, 1.0, 0, 0 -> 1.0.
- Continuous stream of 20 beats with Out_Ready toggling in a 2-high/3-low pattern -> 20 outputs in order, values unchanged while stalled, In_Ready low exactly on stall cycles.
- Assert rst_n low for one cycle after beat 2 of a 4-beat accumulation packet -> outputs 0 immediately. A new 1-beat Last packet of all 2.0 then yields 0x42000000 (32.0), with no stale contribution.

Source files
------------

// File: rtl/fp_adder_tree_n.sv
// rtl/fp_adder_tree_n.sv - pipelined FP32 reduction tree over NUM_IN lanes with optional beat accumulation
module fp_adder_tree_n #(
  parameter int NUM_IN = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [32*NUM_IN-1:0]   Data_In,
  input  logic [NUM_IN-1:0]      Lane_En,
  input  logic                   Valid_In,
  output logic                   In_Ready,
  input  logic                   Acc_Mode,
  input  logic                   Last,
  output logic [31:0]            Data_Out,
  output logic                   Valid_Out,
  input  logic                   Out_Ready
);
  localparam int LEVELS = $clog2(NUM_IN);
  localparam int SLOTS  = 1 << LEVELS;
  localparam int PADW   = 32 * SLOTS;

  // Round-to-nearest-even FP32 add; denormals kept, NaN canonicalised to 0x7FC00000.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my, sh, nrm;
    logic [27:0] sum;
    logic [24:0] rnd;
    logic [9:0]  er;
    logic [4:0]  lz;
    logic        a_nan, b_nan, a_inf, b_inf, stk, rup;
    x = a; y = b; res = 32'd0; ex = 8'd0; ey = 8'd0; d = 8'd0;
    mx = 27'd0; my = 27'd0; sh = 27'd0; nrm = 27'd0; sum = 28'd0;
    rnd = 25'd0; er = 10'd0; lz = 5'd0; stk = 1'b0; rup = 1'b0;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    a_inf = (&a[30:23]) && !(|a[22:0]);
    b_inf = (&b[30:23]) && !(|b[22:0]);
    if (a_nan || b_nan) begin
      res = 32'h7FC00000;
    end else if (a_inf && b_inf) begin
      res = (a[31] != b[31]) ? 32'h7FC00000 : a;
    end else if (a_inf) begin
      res = a;
    end else if (b_inf) begin
      res = b;
    end else begin
      if (a[30:0] < b[30:0]) begin
        x = b;
        y = a;
      end
      ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      mx = {(x[30:23] != 8'd0), x[22:0], 3'b000};
      my = {(y[30:23] != 8'd0), y[22:0], 3'b000};
      d  = ex - ey;
      if (d > 8'd26) begin
        sh  = 27'd0;
        stk = |my;
      end else begin
        sh  = my >> d;
        stk = |(my & ~({27{1'b1}} << d));
      end
      sh[0] = sh[0] | stk;
      er = {2'b00, ex};
      if (x[31] == y[31]) begin
        sum = {1'b0, mx} + {1'b0, sh};
        if (sum[27]) begin
          nrm = {sum[27:2], sum[1] | sum[0]};
          er  = er + 10'd1;
        end else begin
          nrm = sum[26:0];
        end
      end else begin
        nrm = mx - sh;
        lz  = 5'd27;
        for (int i = 0; i < 27; i++)
          if (nrm[i]) lz = 5'(26 - i);
        // never normalise below the minimum exponent: the result becomes denormal instead
        if ({5'd0, lz} >= er) lz = 5'(er - 10'd1);
        nrm = nrm << lz;
        er  = er - {5'd0, lz};
      end
      rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
      rnd = {1'b0, nrm[26:3]} + {24'd0, rup};
      if (rnd[24]) begin
        rnd = rnd >> 1;
        er  = er + 10'd1;
      end
      if (nrm == 27'd0)
        res = (x[31] == y[31]) ? {x[31], 31'd0} : 32'd0;
      else if (er >= 10'd255)
        res = {x[31], 8'hFF, 23'd0};
      else
        res = {x[31], (rnd[23] ? er[7:0] : 8'd0), rnd[22:0]};
    end
    return res;
  endfunction

  logic [PADW-1:0]  data_pad;
  logic [SLOTS-1:0] en_pad;
  logic [31:0]      lvl_q [LEVELS+1][SLOTS];
  logic [31:0]      lvl_d [LEVELS+1][SLOTS];
  logic [LEVELS:0]  vld_q, accm_q, last_q;
  logic [31:0]      acc_q, acc_d, data_out_q, data_out_d, tree_sum, acc_base, acc_sum;
  logic             acc_active_q, acc_active_d, valid_out_q, valid_out_d, stall;

  assign data_pad = PADW'(Data_In);
  assign en_pad   = SLOTS'(Lane_En);

  // Level 0 holds the masked, zero-padded lanes; level k pairs slots 2j and 2j+1 of level k-1.
  always_comb begin
    for (int k = 0; k <= LEVELS; k++)
      for (int j = 0; j < SLOTS; j++)
        lvl_d[k][j] = 32'd0;
    for (int j = 0; j < SLOTS; j++)
      if (en_pad[j]) lvl_d[0][j] = data_pad[32*j +: 32];
    for (int k = 1; k <= LEVELS; k++)
      for (int j = 0; j < (SLOTS >> k); j++)
        lvl_d[k][j] = fp_add(lvl_q[k-1][2*j], lvl_q[k-1][2*j+1]);
  end

  assign stall    = valid_out_q && !Out_Ready;
  assign In_Ready = !stall;
  assign tree_sum = lvl_q[LEVELS][0];
  assign acc_base = acc_active_q ? acc_q : 32'd0;
  assign acc_sum  = fp_add(acc_base, tree_sum);

  always_comb begin
    acc_d        = acc_q;
    acc_active_d = acc_active_q;
    data_out_d   = data_out_q;
    valid_out_d  = valid_out_q;
    if (!stall) begin
      valid_out_d = 1'b0;
      if (vld_q[LEVELS]) begin
        if (!accm_q[LEVELS]) begin
          data_out_d  = tree_sum;
          valid_out_d = 1'b1;
        end else if (!last_q[LEVELS]) begin
          acc_d        = acc_sum;
          acc_active_d = 1'b1;
        end else begin
          data_out_d   = acc_sum;
          valid_out_d  = 1'b1;
          acc_active_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LEVELS; k++)
        for (int j = 0; j < SLOTS; j++)
          lvl_q[k][j] <= 32'd0;
      vld_q  <= '0;
      accm_q <= '0;
      last_q <= '0;
    end else if (!stall) begin
      lvl_q  <= lvl_d;
      vld_q  <= {vld_q[LEVELS-1:0], Valid_In};
      accm_q <= {accm_q[LEVELS-1:0], Acc_Mode};
      last_q <= {last_q[LEVELS-1:0], Last};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= 32'd0;
      acc_active_q <= 1'b0;
      data_out_q   <= 32'd0;
      valid_out_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_active_q <= acc_active_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
    end
  end

  assign Data_Out  = data_out_q;
  assign Valid_Out = valid_out_q;

endmodule

// File: tb/tb_fp_adder_tree_n.sv
// tb/tb_fp_adder_tree_n.sv - randomized scoreboard bench for fp_adder_tree_n (16 and 5 lanes)
module tb_fp_adder_tree_n;
  localparam int N  = 16;
  localparam int LV = 4;
  localparam int N5 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [32*N-1:0]  din;
  logic [N-1:0]     len;
  logic             vin, irdy, am, last, vout, ordy;
  logic [31:0]      dout;
  logic [32*N5-1:0] din5;
  logic [N5-1:0]    len5;
  logic             vin5, irdy5, am5, last5, vout5, ordy5;
  logic [31:0]      dout5;

  fp_adder_tree_n #(.NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .Data_In(din), .Lane_En(len), .Valid_In(vin), .In_Ready(irdy),
    .Acc_Mode(am), .Last(last), .Data_Out(dout), .Valid_Out(vout), .Out_Ready(ordy)
  );

  fp_adder_tree_n #(.NUM_IN(N5)) dut5 (
    .clk(clk), .rst_n(rst_n), .Data_In(din5), .Lane_En(len5), .Valid_In(vin5), .In_Ready(irdy5),
    .Acc_Mode(am5), .Last(last5), .Data_Out(dout5), .Valid_Out(vout5), .Out_Ready(ordy5)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] ovr_q[$];
  logic [31:0] m_acc = 32'h0;
  bit          m_active = 1'b0;
  bit          lat_mode = 1'b0;
  bit          acc_flag = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_dout = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: FP32 operands are exact in double; the double sum rounded once to FP32 is the correctly rounded result.
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    m = real'(b[22:0]);
    if (e == 0) m = m * (2.0 ** real'(-149));
    else        m = (m + 8388608.0) * (2.0 ** real'(e - 150));
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    logic [23:0] m;
    logic [28:0] rest;
    int          e;
    bit          up;
    d = $realtobits(x);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e    = int'(d[62:52]) - 1023 + 127;
    m    = {1'b1, d[51:29]};
    rest = d[28:0];
    up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && m[0]);
    if (up) begin
      if (m == 24'hFFFFFF) begin
        m = 24'h800000;
        e++;
      end else begin
        m = m + 24'd1;
      end
    end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] model_tree(input logic [31:0] lanes[$]);
    logic [31:0] cur[$];
    logic [31:0] nxt[$];
    cur = lanes;
    while ((cur.size() & (cur.size() - 1)) != 0) cur.push_back(32'h0);
    while (cur.size() > 1) begin
      nxt = {};
      for (int i = 0; i < cur.size(); i += 2) nxt.push_back(fadd(cur[i], cur[i+1]));
      cur = nxt;
    end
    return cur[0];
  endfunction

  function automatic logic [31:0] rand_f();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = 8'($urandom_range(110, 140));
    r[22:0]  = 23'($urandom);
    return r;
  endfunction

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back((ovr_q.size() > 0) ? ovr_q.pop_front() : v);
    lat_q.push_back(lat_mode ? cyc + 1 : -1);
  endtask

  task automatic rand_beat(input bit mixed);
    for (int i = 0; i < N; i++) din[32*i +: 32] = rand_f();
    len  = N'($urandom);
    am   = mixed ? 1'($urandom_range(0, 1)) : 1'b0;
    last = mixed ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // One clock of the 16-lane DUT: observe at negedge, update the model on acceptance, return 1 after the edge.
  task automatic step();
    logic [31:0] e, t;
    logic [31:0] lanes[$];
    int          le;
    @(negedge clk);
    acc_flag = 1'b0;
    check_eq("in_ready", 32'(irdy), 32'(!(vout && !ordy)));
    if (prev_stall) begin
      check_eq("stall_data", dout, prev_dout);
      check_eq("stall_vld", 32'(vout), 32'd1);
    end
    if (vout) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(vout), 32'd0);
      end else if (ordy) begin
        e  = exp_q.pop_front();
        le = lat_q.pop_front();
        check_eq("data_out", dout, e);
        if (le >= 0) check_eq("latency", 32'(cyc - le), 32'(LV + 1));
      end
    end
    if (vin && irdy) begin
      acc_flag = 1'b1;
      lanes = {};
      for (int i = 0; i < N; i++) lanes.push_back(len[i] ? din[32*i +: 32] : 32'h0);
      t = model_tree(lanes);
      if (!am) begin
        push_exp(t);
      end else if (!last) begin
        m_acc    = fadd(m_active ? m_acc : 32'h0, t);
        m_active = 1'b1;
      end else begin
        push_exp(fadd(m_active ? m_acc : 32'h0, t));
        m_active = 1'b0;
      end
    end
    prev_stall = vout && !ordy;
    prev_dout  = dout;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    vin  = 1'b0;
    ordy = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (LV + 2) step();
  endtask

  task automatic run5(input string tag, input logic [32*N5-1:0] data, input logic [31:0] exp);
    int n;
    din5 = data;
    len5 = '1;
    vin5 = 1'b1;
    check_eq({tag, "_rdy"}, 32'(irdy5), 32'd1);
    @(posedge clk);
    #1;
    vin5 = 1'b0;
    for (n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (vout5) break;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'd4);
    check_eq({tag, "_data"}, dout5, exp);
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, 32'(vout5), 32'd0);
  endtask

  initial begin
    int n;
    din = '0; len = '1; vin = 1'b0; am = 1'b0; last = 1'b0; ordy = 1'b1;
    din5 = '0; len5 = '1; vin5 = 1'b0; am5 = 1'b0; last5 = 1'b0; ordy5 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", dout, 32'h0);
    check_eq("rst_vout", 32'(vout), 32'd0);
    check_eq("rst_irdy", 32'(irdy), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lat_mode = 1'b1;
    for (int i = 0; i < N; i++) din[32*i +: 32] = 32'h3F800000;
    len = '1; am = 1'b0; last = 1'b0; vin = 1'b1;
    ovr_q.push_back(32'h41800000);
    step();
    drain();

    len = 16'h00FF; vin = 1'b1;
    ovr_q.push_back(32'h41000000);
    step();
    drain();

    din[32*3 +: 32] = 32'h7FC00001;
    len = 16'h01F7; vin = 1'b1;
    ovr_q.push_back(32'h41000000);
    step();
    drain();

    for (int i = 0; i < N; i++) din[32*i +: 32] = 32'h3F800000;
    len = '1; am = 1'b1; vin = 1'b1;
    last = 1'b0; step();
    last = 1'b0; step();
    last = 1'b1;
    ovr_q.push_back(32'h42400000);
    step();
    am = 1'b0; last = 1'b0;
    drain();

    run5("n5_seq", {32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 32'h41700000);
    run5("n5_cancel", {32'h0, 32'h0, 32'h3F800000, 32'hCCBEBC20, 32'h4CBEBC20}, 32'h3F800000);
    run5("n5_absorb", {32'h0, 32'h0, 32'hCCBEBC20, 32'h4CBEBC20, 32'h3F800000}, 32'h00000000);

    lat_mode = 1'b0;
    rand_beat(1'b0);
    vin = 1'b1;
    n = 0;
    for (int g = 0; g < 400 && n < 20; g++) begin
      ordy = (g % 5) < 2;
      step();
      if (acc_flag) begin
        n++;
        if (n < 20) rand_beat(1'b0);
      end
    end
    vin = 1'b0;
    check_eq("stream_beats", 32'(n), 32'd20);
    drain();

    for (int g = 0; g < 300; g++) begin
      if (!vin || acc_flag) begin
        rand_beat(1'b1);
        vin = ($urandom_range(0, 3) != 0);
      end
      ordy = ($urandom_range(0, 2) != 0);
      step();
    end
    am = 1'b1; last = 1'b1; vin = 1'b1; ordy = 1'b1;
    step();
    while (!acc_flag) step();
    am = 1'b0; last = 1'b0;
    drain();

    for (int i = 0; i < N; i++) din[32*i +: 32] = 32'h3F800000;
    len = '1; am = 1'b1; last = 1'b0; vin = 1'b1;
    step();
    step();
    vin = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_dout", dout, 32'h0);
    check_eq("midrst_vout", 32'(vout), 32'd0);
    check_eq("midrst_irdy", 32'(irdy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    lat_q.delete();
    m_acc = 32'h0;
    m_active = 1'b0;
    prev_stall = 1'b0;
    lat_mode = 1'b1;
    for (int i = 0; i < N; i++) din[32*i +: 32] = 32'h40000000;
    am = 1'b1; last = 1'b1; vin = 1'b1;
    ovr_q.push_back(32'h42000000);
    step();
    am = 1'b0; last = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
